// File: rtl/toy_bus_arb_node_mem.sv
// -----------------------------------------------------------------------------
// toy_bus_arb_node_mem
//   Four-port round-robin request arbiter in front of a single memory target.
//   Requests from in0..in3 are merged onto out0_req_*. Acks from out0_ack_* are
//   routed back to the port whose PORTn_ID matches out0_ack_tgt_id. Acks that
//   match no port are dropped.
//
//   Optional feature (macro TOY_BUS_ARB_OUT_REG_EN):
//     defined   : out0_req_* is driven from a 1-entry register slice (latency 1,
//                 full throughput).
//     undefined : out0_req_* is a combinational mux of the granted input
//                 (latency 0).
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   inN_req_vld / inN_req_rdy      upstream request handshake (N = 0..3)
//   inN_req_addr/strb/data/opcode/src_id/tgt_id   upstream request payload
//   inN_ack_vld / inN_ack_rdy      upstream ack handshake
//   inN_ack_opcode/data/src_id/tgt_id             ack payload (broadcast)
//   out0_req_vld / out0_req_rdy    request to the memory target, plus payload
//   out0_ack_vld / out0_ack_rdy    ack from the memory target, plus payload
//   ack_route_err                  one-cycle pulse after an ack is dropped
// -----------------------------------------------------------------------------
module toy_bus_arb_node_mem #(
  parameter logic [3:0] PORT0_ID  = 4'd0,
  parameter logic [3:0] PORT1_ID  = 4'd1,
  parameter logic [3:0] PORT2_ID  = 4'd2,
  parameter logic [3:0] PORT3_ID  = 4'd3,
  parameter int         MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // upstream port 0
  input  logic        in0_req_vld,
  output logic        in0_req_rdy,
  input  logic [31:0] in0_req_addr,
  input  logic [3:0]  in0_req_strb,
  input  logic [31:0] in0_req_data,
  input  logic        in0_req_opcode,
  input  logic [3:0]  in0_req_src_id,
  input  logic [3:0]  in0_req_tgt_id,
  output logic        in0_ack_vld,
  input  logic        in0_ack_rdy,
  output logic        in0_ack_opcode,
  output logic [31:0] in0_ack_data,
  output logic [3:0]  in0_ack_src_id,
  output logic [3:0]  in0_ack_tgt_id,
  // upstream port 1
  input  logic        in1_req_vld,
  output logic        in1_req_rdy,
  input  logic [31:0] in1_req_addr,
  input  logic [3:0]  in1_req_strb,
  input  logic [31:0] in1_req_data,
  input  logic        in1_req_opcode,
  input  logic [3:0]  in1_req_src_id,
  input  logic [3:0]  in1_req_tgt_id,
  output logic        in1_ack_vld,
  input  logic        in1_ack_rdy,
  output logic        in1_ack_opcode,
  output logic [31:0] in1_ack_data,
  output logic [3:0]  in1_ack_src_id,
  output logic [3:0]  in1_ack_tgt_id,
  // upstream port 2
  input  logic        in2_req_vld,
  output logic        in2_req_rdy,
  input  logic [31:0] in2_req_addr,
  input  logic [3:0]  in2_req_strb,
  input  logic [31:0] in2_req_data,
  input  logic        in2_req_opcode,
  input  logic [3:0]  in2_req_src_id,
  input  logic [3:0]  in2_req_tgt_id,
  output logic        in2_ack_vld,
  input  logic        in2_ack_rdy,
  output logic        in2_ack_opcode,
  output logic [31:0] in2_ack_data,
  output logic [3:0]  in2_ack_src_id,
  output logic [3:0]  in2_ack_tgt_id,
  // upstream port 3
  input  logic        in3_req_vld,
  output logic        in3_req_rdy,
  input  logic [31:0] in3_req_addr,
  input  logic [3:0]  in3_req_strb,
  input  logic [31:0] in3_req_data,
  input  logic        in3_req_opcode,
  input  logic [3:0]  in3_req_src_id,
  input  logic [3:0]  in3_req_tgt_id,
  output logic        in3_ack_vld,
  input  logic        in3_ack_rdy,
  output logic        in3_ack_opcode,
  output logic [31:0] in3_ack_data,
  output logic [3:0]  in3_ack_src_id,
  output logic [3:0]  in3_ack_tgt_id,
  // memory target
  output logic        out0_req_vld,
  input  logic        out0_req_rdy,
  output logic [31:0] out0_req_addr,
  output logic [3:0]  out0_req_strb,
  output logic [31:0] out0_req_data,
  output logic        out0_req_opcode,
  output logic [3:0]  out0_req_src_id,
  output logic [3:0]  out0_req_tgt_id,
  input  logic        out0_ack_vld,
  output logic        out0_ack_rdy,
  input  logic        out0_ack_opcode,
  input  logic [31:0] out0_ack_data,
  input  logic [3:0]  out0_ack_src_id,
  input  logic [3:0]  out0_ack_tgt_id,
  output logic        ack_route_err
);

  localparam logic [15:0] PORT_IDS  = {PORT3_ID, PORT2_ID, PORT1_ID, PORT0_ID};
  localparam logic [3:0]  MAX_OUT_W = 4'(MAX_OUTST);

  // ---------------------------------------------------------------------------
  // Gather the four upstream ports into indexable arrays
  // ---------------------------------------------------------------------------
  logic [3:0]  w_req_vld;
  logic [31:0] w_req_addr [4];
  logic [3:0]  w_req_strb [4];
  logic [31:0] w_req_data [4];
  logic        w_req_op   [4];
  logic [3:0]  w_req_src  [4];
  logic [3:0]  w_req_tgt  [4];
  logic [3:0]  w_req_rdy;
  logic [3:0]  w_ack_rdy;
  logic [3:0]  w_ack_vld;

  assign w_req_vld  = {in3_req_vld, in2_req_vld, in1_req_vld, in0_req_vld};
  assign w_req_addr[0] = in0_req_addr;   assign w_req_addr[1] = in1_req_addr;
  assign w_req_addr[2] = in2_req_addr;   assign w_req_addr[3] = in3_req_addr;
  assign w_req_strb[0] = in0_req_strb;   assign w_req_strb[1] = in1_req_strb;
  assign w_req_strb[2] = in2_req_strb;   assign w_req_strb[3] = in3_req_strb;
  assign w_req_data[0] = in0_req_data;   assign w_req_data[1] = in1_req_data;
  assign w_req_data[2] = in2_req_data;   assign w_req_data[3] = in3_req_data;
  assign w_req_op[0]   = in0_req_opcode; assign w_req_op[1]   = in1_req_opcode;
  assign w_req_op[2]   = in2_req_opcode; assign w_req_op[3]   = in3_req_opcode;
  assign w_req_src[0]  = in0_req_src_id; assign w_req_src[1]  = in1_req_src_id;
  assign w_req_src[2]  = in2_req_src_id; assign w_req_src[3]  = in3_req_src_id;
  assign w_req_tgt[0]  = in0_req_tgt_id; assign w_req_tgt[1]  = in1_req_tgt_id;
  assign w_req_tgt[2]  = in2_req_tgt_id; assign w_req_tgt[3]  = in3_req_tgt_id;
  assign w_ack_rdy     = {in3_ack_rdy, in2_ack_rdy, in1_ack_rdy, in0_ack_rdy};

  assign in0_req_rdy = w_req_rdy[0];
  assign in1_req_rdy = w_req_rdy[1];
  assign in2_req_rdy = w_req_rdy[2];
  assign in3_req_rdy = w_req_rdy[3];
  assign in0_ack_vld = w_ack_vld[0];
  assign in1_ack_vld = w_ack_vld[1];
  assign in2_ack_vld = w_ack_vld[2];
  assign in3_ack_vld = w_ack_vld[3];

  // ---------------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------------
  logic [1:0] r_ptr;       // round-robin priority pointer
  logic       r_lock;      // grant held from the previous cycle
  logic [1:0] r_gnt_idx;   // port held while r_lock is set
  logic [2:0] r_outst;     // requests accepted by the target, not yet acked

  logic       w_rr_found;
  logic [1:0] w_rr_idx;
  logic       w_gnt_vld;
  logic [1:0] w_gnt_idx;
  logic [3:0] w_inflight;
  logic       w_below;
  logic       w_stage_rdy;
  logic       w_take;      // request handshake on the granted upstream port
  logic       w_out_hs;    // request handshake on out0
  logic       w_ack_hs;    // ack handshake on out0

  // Search the ports starting at the pointer; first requester wins.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_ptr;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] cand;
      cand = r_ptr + 2'(i);
      if (!w_rr_found && w_req_vld[cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = cand;
      end
    end
  end

  assign w_gnt_idx = r_lock ? r_gnt_idx : w_rr_idx;
  assign w_gnt_vld = r_lock ? w_req_vld[r_gnt_idx] : w_rr_found;

  // An entry sitting in the register slice counts as in flight as well, so the
  // target never sees more than MAX_OUTST requests it has not acked.
`ifdef TOY_BUS_ARB_OUT_REG_EN
  logic r_slc_vld;
  assign w_inflight = {1'b0, r_outst} + {3'b000, r_slc_vld};
`else
  assign w_inflight = {1'b0, r_outst};
`endif
  assign w_below = (w_inflight < MAX_OUT_W);

  // rst_n gates the ready/valid outputs directly so they are 0 for the whole
  // reset interval, not only after the first clock edge.
  assign w_take = rst_n && w_gnt_vld && w_below && w_stage_rdy;

  always_comb begin
    w_req_rdy = 4'b0000;
    if (rst_n && w_gnt_vld && w_below && w_stage_rdy) w_req_rdy[w_gnt_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef TOY_BUS_ARB_OUT_REG_EN
  logic [31:0] r_slc_addr;
  logic [3:0]  r_slc_strb;
  logic [31:0] r_slc_data;
  logic        r_slc_op;
  logic [3:0]  r_slc_src;
  logic [3:0]  r_slc_tgt;

  // Accept when empty, or when the current entry leaves this same cycle.
  assign w_stage_rdy = !r_slc_vld || out0_req_rdy;
  assign w_out_hs    = r_slc_vld && out0_req_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_slc_vld <= 1'b0;
    else if (w_take)   r_slc_vld <= 1'b1;
    else if (w_out_hs) r_slc_vld <= 1'b0;
  end

  // NOTE: payload is qualified by r_slc_vld, so it carries no reset; only the
  // control bit needs one.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_slc_addr <= w_req_addr[w_gnt_idx];
      r_slc_strb <= w_req_strb[w_gnt_idx];
      r_slc_data <= w_req_data[w_gnt_idx];
      r_slc_op   <= w_req_op[w_gnt_idx];
      r_slc_src  <= w_req_src[w_gnt_idx];
      r_slc_tgt  <= w_req_tgt[w_gnt_idx];
    end
  end

  assign out0_req_vld    = r_slc_vld;
  assign out0_req_addr   = r_slc_addr;
  assign out0_req_strb   = r_slc_strb;
  assign out0_req_data   = r_slc_data;
  assign out0_req_opcode = r_slc_op;
  assign out0_req_src_id = r_slc_src;
  assign out0_req_tgt_id = r_slc_tgt;
`else
  assign w_stage_rdy     = out0_req_rdy;
  assign out0_req_vld    = rst_n && w_gnt_vld && w_below;
  assign w_out_hs        = out0_req_vld && out0_req_rdy;
  assign out0_req_addr   = w_req_addr[w_gnt_idx];
  assign out0_req_strb   = w_req_strb[w_gnt_idx];
  assign out0_req_data   = w_req_data[w_gnt_idx];
  assign out0_req_opcode = w_req_op[w_gnt_idx];
  assign out0_req_src_id = w_req_src[w_gnt_idx];
  assign out0_req_tgt_id = w_req_tgt[w_gnt_idx];
`endif

  // ---------------------------------------------------------------------------
  // Ack routing: scan high to low so the lowest matching port wins.
  // ---------------------------------------------------------------------------
  logic       w_ack_hit;
  logic [1:0] w_ack_sel;

  always_comb begin
    w_ack_hit = 1'b0;
    w_ack_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (out0_ack_tgt_id == PORT_IDS[i*4 +: 4]) begin
        w_ack_hit = 1'b1;
        w_ack_sel = 2'(i);
      end
    end
  end

  always_comb begin
    w_ack_vld = 4'b0000;
    if (out0_ack_vld && w_ack_hit) w_ack_vld[w_ack_sel] = 1'b1;
  end

  // Unroutable acks are always consumed so they cannot block the target.
  assign out0_ack_rdy = w_ack_hit ? w_ack_rdy[w_ack_sel] : 1'b1;
  assign w_ack_hs     = out0_ack_vld && out0_ack_rdy;

  assign in0_ack_opcode = out0_ack_opcode;
  assign in1_ack_opcode = out0_ack_opcode;
  assign in2_ack_opcode = out0_ack_opcode;
  assign in3_ack_opcode = out0_ack_opcode;
  assign in0_ack_data   = out0_ack_data;
  assign in1_ack_data   = out0_ack_data;
  assign in2_ack_data   = out0_ack_data;
  assign in3_ack_data   = out0_ack_data;
  assign in0_ack_src_id = out0_ack_src_id;
  assign in1_ack_src_id = out0_ack_src_id;
  assign in2_ack_src_id = out0_ack_src_id;
  assign in3_ack_src_id = out0_ack_src_id;
  assign in0_ack_tgt_id = out0_ack_tgt_id;
  assign in1_ack_tgt_id = out0_ack_tgt_id;
  assign in2_ack_tgt_id = out0_ack_tgt_id;
  assign in3_ack_tgt_id = out0_ack_tgt_id;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  logic r_route_err;
  assign ack_route_err = r_route_err;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 2'd0;
      r_lock      <= 1'b0;
      r_gnt_idx   <= 2'd0;
      r_outst     <= 3'd0;
      r_route_err <= 1'b0;
    end else begin
      // Hold the grant until the granted request is actually taken, keeping
      // out0 payload stable while the target back-pressures.
      r_lock    <= w_gnt_vld && !w_take;
      r_gnt_idx <= w_gnt_idx;
      if (w_take) r_ptr <= w_gnt_idx + 2'd1;

      // Saturating counter; simultaneous inc and dec hold.
      if (w_out_hs && !w_ack_hs) begin
        if (r_outst != 3'd7) r_outst <= r_outst + 3'd1;
      end else if (w_ack_hs && !w_out_hs) begin
        if (r_outst != 3'd0) r_outst <= r_outst - 3'd1;
      end

      r_route_err <= out0_ack_vld && !w_ack_hit;
    end
  end

endmodule

// File: tb/tb_toy_bus_arb_node_mem.sv
// -----------------------------------------------------------------------------
// tb_toy_bus_arb_node_mem
//   Directed bench for toy_bus_arb_node_mem in its default (combinational
//   output) build with MAX_OUTST=2. Inputs change #1 after a rising edge or on
//   a falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_toy_bus_arb_node_mem;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  req_vld;
  logic [31:0] req_addr [4];
  logic [3:0]  req_strb [4];
  logic [31:0] req_data [4];
  logic        req_op   [4];
  logic [3:0]  req_src  [4];
  logic [3:0]  req_tgt  [4];
  wire  [3:0]  req_rdy;
  wire  [3:0]  ack_vld;
  logic [3:0]  ack_rdy;
  wire         ack_op_o   [4];
  wire  [31:0] ack_data_o [4];
  wire  [3:0]  ack_src_o  [4];
  wire  [3:0]  ack_tgt_o  [4];

  wire         o_vld;
  logic        o_rdy;
  wire  [31:0] o_addr, o_data;
  wire  [3:0]  o_strb, o_src, o_tgt;
  wire         o_op;

  logic        a_vld;
  wire         a_rdy;
  logic        a_op;
  logic [31:0] a_data;
  logic [3:0]  a_src, a_tgt;
  wire         route_err;

  toy_bus_arb_node_mem #(.MAX_OUTST(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_req_vld(req_vld[0]), .in0_req_rdy(req_rdy[0]), .in0_req_addr(req_addr[0]),
    .in0_req_strb(req_strb[0]), .in0_req_data(req_data[0]), .in0_req_opcode(req_op[0]),
    .in0_req_src_id(req_src[0]), .in0_req_tgt_id(req_tgt[0]),
    .in0_ack_vld(ack_vld[0]), .in0_ack_rdy(ack_rdy[0]), .in0_ack_opcode(ack_op_o[0]),
    .in0_ack_data(ack_data_o[0]), .in0_ack_src_id(ack_src_o[0]), .in0_ack_tgt_id(ack_tgt_o[0]),
    .in1_req_vld(req_vld[1]), .in1_req_rdy(req_rdy[1]), .in1_req_addr(req_addr[1]),
    .in1_req_strb(req_strb[1]), .in1_req_data(req_data[1]), .in1_req_opcode(req_op[1]),
    .in1_req_src_id(req_src[1]), .in1_req_tgt_id(req_tgt[1]),
    .in1_ack_vld(ack_vld[1]), .in1_ack_rdy(ack_rdy[1]), .in1_ack_opcode(ack_op_o[1]),
    .in1_ack_data(ack_data_o[1]), .in1_ack_src_id(ack_src_o[1]), .in1_ack_tgt_id(ack_tgt_o[1]),
    .in2_req_vld(req_vld[2]), .in2_req_rdy(req_rdy[2]), .in2_req_addr(req_addr[2]),
    .in2_req_strb(req_strb[2]), .in2_req_data(req_data[2]), .in2_req_opcode(req_op[2]),
    .in2_req_src_id(req_src[2]), .in2_req_tgt_id(req_tgt[2]),
    .in2_ack_vld(ack_vld[2]), .in2_ack_rdy(ack_rdy[2]), .in2_ack_opcode(ack_op_o[2]),
    .in2_ack_data(ack_data_o[2]), .in2_ack_src_id(ack_src_o[2]), .in2_ack_tgt_id(ack_tgt_o[2]),
    .in3_req_vld(req_vld[3]), .in3_req_rdy(req_rdy[3]), .in3_req_addr(req_addr[3]),
    .in3_req_strb(req_strb[3]), .in3_req_data(req_data[3]), .in3_req_opcode(req_op[3]),
    .in3_req_src_id(req_src[3]), .in3_req_tgt_id(req_tgt[3]),
    .in3_ack_vld(ack_vld[3]), .in3_ack_rdy(ack_rdy[3]), .in3_ack_opcode(ack_op_o[3]),
    .in3_ack_data(ack_data_o[3]), .in3_ack_src_id(ack_src_o[3]), .in3_ack_tgt_id(ack_tgt_o[3]),
    .out0_req_vld(o_vld), .out0_req_rdy(o_rdy), .out0_req_addr(o_addr),
    .out0_req_strb(o_strb), .out0_req_data(o_data), .out0_req_opcode(o_op),
    .out0_req_src_id(o_src), .out0_req_tgt_id(o_tgt),
    .out0_ack_vld(a_vld), .out0_ack_rdy(a_rdy), .out0_ack_opcode(a_op),
    .out0_ack_data(a_data), .out0_ack_src_id(a_src), .out0_ack_tgt_id(a_tgt),
    .ack_route_err(route_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Grant order expected with all four ports requesting from reset.
  logic [1:0] exp_order [5];

  initial begin
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n   = 1'b0;
    req_vld = 4'hF;
    for (int n = 0; n < 4; n++) begin
      req_addr[n] = 32'h0000_0100 * n;
      req_strb[n] = 4'hF;
      req_data[n] = 32'hA000_0000 + n;
      req_op[n]   = n[0];
      req_src[n]  = 4'(n);
      req_tgt[n]  = 4'h0;
    end
    ack_rdy = 4'hF;
    o_rdy   = 1'b1;
    a_vld   = 1'b0;
    a_op    = 1'b0;
    a_data  = 32'h0;
    a_src   = 4'h0;
    a_tgt   = 4'h0;

    // Reset state with every port requesting.
    #3;
    check("rst_out_vld", o_vld, 0);
    check("rst_in_rdy", req_rdy, 4'b0000);
    check("rst_route_err", route_err, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Unroutable acks each cycle keep the counter pinned at 0.
    a_vld = 1'b1; a_tgt = 4'hF;

    // Round-robin 0,1,2,3,0 with one handshake per cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rr_rdy_%0d", i), req_rdy, 4'b0001 << exp_order[i]);
      check($sformatf("rr_data_%0d", i), o_data, 32'hA000_0000 + exp_order[i]);
    end
    @(posedge clk);
    #1 req_vld = 4'b0000; a_vld = 1'b0;

    // Port 2 granted under back-pressure; port 0 joins; payload stays port 2.
    req_vld = 4'b0100; o_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("lock_vld_%0d", i), o_vld, 1);
      check($sformatf("lock_data_%0d", i), o_data, 32'hA000_0002);
      check($sformatf("lock_rdy_%0d", i), req_rdy, 4'b0000);
      @(posedge clk);
      #1 req_vld = 4'b0101;
    end
    o_rdy = 1'b1;
    @(negedge clk);
    check("lock_accept_rdy", req_rdy, 4'b0100);
    check("lock_accept_src", o_src, 4'd2);
    @(negedge clk);
    check("after_lock_rdy", req_rdy, 4'b0001);
    @(posedge clk);
    #1 req_vld = 4'b0000;   // two requests now outstanding

    // Unroutable ack: consumed at once, error pulse next cycle, count -> 1.
    a_vld = 1'b1; a_tgt = 4'hF; a_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("bad_ack_rdy", a_rdy, 1);
    check("bad_ack_vld", ack_vld, 4'b0000);
    check("bad_ack_err_pre", route_err, 0);
    @(posedge clk);
    #1 a_vld = 1'b0;
    @(negedge clk);
    check("bad_ack_err", route_err, 1);
    @(negedge clk);
    check("bad_ack_err_clr", route_err, 0);

    // Ack to port 3 stalled two cycles by in3_ack_rdy=0; count -> 0 on accept.
    @(posedge clk);
    #1 a_vld = 1'b1; a_tgt = 4'd3; a_data = 32'h1234_5678; ack_rdy = 4'b0111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("ack3_rdy_%0d", i), a_rdy, 0);
      check($sformatf("ack3_vld_%0d", i), ack_vld, 4'b1000);
      check($sformatf("ack3_bcast_%0d", i), ack_data_o[0], 32'h1234_5678);
    end
    @(posedge clk);
    #1 ack_rdy = 4'hF;
    @(negedge clk);
    check("ack3_go", a_rdy, 1);
    @(posedge clk);
    #1 a_vld = 1'b0;

    // Outstanding limit: third request from port 1 waits for an ack.
    req_vld = 4'b0010;
    @(negedge clk);
    check("lim_req1", req_rdy, 4'b0010);
    @(negedge clk);
    check("lim_req2", req_rdy, 4'b0010);
    @(negedge clk);
    check("lim_stall_rdy", req_rdy, 4'b0000);
    check("lim_stall_vld", o_vld, 0);
    @(negedge clk);
    check("lim_stall_rdy2", req_rdy, 4'b0000);
    a_vld = 1'b1; a_tgt = 4'd1; a_data = 32'h0000_0011;
    #1;
    check("lim_ack_vld", ack_vld, 4'b0010);
    check("lim_ack_rdy", a_rdy, 1);
    check("lim_still_stall", req_rdy, 4'b0000);
    @(posedge clk);
    #1 a_vld = 1'b0;
    @(negedge clk);
    check("lim_req3", req_rdy, 4'b0010);
    @(posedge clk);
    // Count back at 2, pointer at port 2.

    // Mid-burst asynchronous reset.
    #1 req_vld = 4'hF; a_vld = 1'b1; a_tgt = 4'hF;
    @(negedge clk);
    check("burst_stall", o_vld, 0);
    @(negedge clk);
    check("burst_rdy", req_rdy, 4'b0100);
    check("burst_vld", o_vld, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_vld", o_vld, 0);
    check("async_rst_rdy", req_rdy, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1; a_vld = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", req_rdy, 4'b0001);
    check("post_rst_data", o_data, 32'hA000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toy_bus_arb_node_mem.md
TOY_BUS_ARB_NODE_MEM -- requirements
Module: toy_bus_arb_node_mem

Interface
REQ-001 Parameter PORT0_ID, default 4'd0: bus ID owned by upstream port 0; parameters PORT1_ID, PORT2_ID and PORT3_ID, defaults 4'd1, 4'd2 and 4'd3, do the same for ports 1-3.
REQ-002 Parameter MAX_OUTST, default 4: maximum number of requests in flight, legal range 1..7.
REQ-003 clk  input  1  sole clock, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 inN_req_vld/inN_req_rdy (N=0..3)  input/output  1/1  upstream request handshake.
REQ-006 inN_req_addr/strb/data/opcode/src_id/tgt_id  input  32/4/32/1/4/4  upstream request payload.
REQ-007 inN_ack_vld/inN_ack_rdy  output/input  1/1  upstream ack handshake.
REQ-008 inN_ack_opcode/data/src_id/tgt_id  output  1/32/4/4  upstream ack payload.
REQ-009 out0_req_vld/out0_req_rdy  output/input  1/1, plus out0_req_addr/strb/data/opcode/src_id/tgt_id  output  32/4/32/1/4/4  request to the memory target.
REQ-010 out0_ack_vld/out0_ack_rdy  input/output  1/1, plus out0_ack_opcode/data/src_id/tgt_id  input  1/32/4/4  ack from the memory target.
REQ-011 ack_route_err  output  1  one-cycle pulse when an ack is dropped.

Function
REQ-012 A transfer occurs on any channel in a cycle where vld and rdy are both 1.
REQ-013 Request arbitration SHALL be round-robin over ports 0-3, with a priority pointer that starts at port 0 and moves to (k+1) mod 4 after a request handshake from port k.
REQ-014 Once a port is granted and out0_req_vld=1 without a handshake, the grant SHALL be locked (lock flag) so that payload and grant are stable until out0_req_rdy=1.
REQ-015 inN_req_rdy SHALL be 1 only for the granted port, and only when the output stage can accept and the outstanding count is below MAX_OUTST.
REQ-016 The outstanding counter (3 bits) SHALL increment on each out0 request handshake, decrement on each out0 ack handshake, hold on a simultaneous increment and decrement, and never wrap.
REQ-017 When the counter equals MAX_OUTST, all inN_req_rdy SHALL be 0; acks are still accepted.
REQ-018 The ack path is combinational: the port is selected where out0_ack_tgt_id == PORTn_ID, that port's inN_ack_vld=out0_ack_vld, and out0_ack_rdy equals that port's inN_ack_rdy.
REQ-019 Ack payload SHALL be broadcast to all inN_ack_* ports; only the selected port sees vld=1.
REQ-020 An ack whose tgt_id matches no PORTn_ID SHALL be consumed (out0_ack_rdy=1), SHALL decrement the counter, and SHALL pulse ack_route_err for one cycle.
REQ-021 If two PORTn_ID values are equal, the lowest n SHALL win the ack.

Reset
REQ-022 While rst_n=0: out0_req_vld=0, all inN_req_rdy=0, pointer=0, lock=0, counter=0, ack_route_err=0, output register empty.
REQ-023 Transactions in flight when reset is asserted mid-operation SHALL be discarded; no state is retained.

Configuration
REQ-024 Macro TOY_BUS_ARB_OUT_REG_EN, defined: out0_req_* SHALL be driven from a 1-entry register slice, giving request latency 1 cycle; the slice accepts a new entry when it is empty or when it is draining that cycle, so full throughput is kept.
REQ-025 Macro TOY_BUS_ARB_OUT_REG_EN, undefined: out0_req_* SHALL be a combinational mux of the granted input, giving latency 0.

Verification
REQ-026 Ports 0-3 all hold vld=1 from reset with out0_req_rdy=1 -> grant order 0,1,2,3,0, with one handshake per cycle.
REQ-027 Port 2 wins the grant while out0_req_rdy=0 for 3 cycles, then port 0 raises vld -> out0 payload stays port 2's and is accepted on the 4th cycle.
REQ-028 MAX_OUTST=2 with no acks and 3 requests from port 1 -> the third request stalls until an ack with tgt_id=1 is accepted.
REQ-029 Ack with tgt_id=4'd3 and in3_ack_rdy=0 for 2 cycles -> out0_ack_rdy=0 for those cycles, and only in3_ack_vld=1.
REQ-030 Ack with tgt_id=4'hF -> consumed in the same cycle, ack_route_err=1 for one cycle, counter decrements.
REQ-031 rst_n pulled low mid-burst with the register slice full -> out0_req_vld=0 asynchronously; after release the first grant goes to port 0.
